// File: rtl/phantom_clock.sv
// DS1215-style phantom time chip: spots a 64-bit serial key on A2 across memory accesses,
// then steals the next 64 accesses to shift a BCD real-time clock in or out on D0.
module phantom_clock #(
    parameter int          TICKDIV = 71591,
    parameter logic [63:0] KEY     = 64'h5CA33AC55CA33AC5
) (
    input  logic C7M,
    input  logic RES,
    input  logic nCE,
    input  logic A0,
    input  logic A2,
    output logic RAMROMCSgb,
    output logic DQ,
    output logic DQOE
);

    typedef enum logic {MATCH, XFER} state_t;

    localparam int          PW         = $clog2(TICKDIV + 1);
    localparam logic [63:0] TIME_RESET = 64'h0001_0101_0000_0000;

    logic          nce1_q, nce1_d, nce2_q, nce2_d;
    logic          a0_q, a0_d, a2_q, a2_d;
    state_t        state_q, state_d;
    logic [5:0]    idx_q, idx_d;
    logic          dirty_q, dirty_d;
    logic [63:0]   sh_q, sh_d;
    logic [63:0]   tm_q, tm_d;
    logic [PW-1:0] presc_q, presc_d;

    logic          evt, tick, dirty_w;
    logic [7:0]    dmax;
    logic [63:0]   tm_tick, sh_w;

    // Fields at or above their maximum (including invalid BCD) fall back to the minimum.
    function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] lo,
                                           input logic [7:0] hi);
        if (v >= hi)
            return lo;
        if (v[3:0] >= 4'd9)
            return {v[7:4] + 4'd1, 4'd0};
        return {v[7:4], v[3:0] + 4'd1};
    endfunction

    function automatic logic [7:0] month_len(input logic [7:0] mon, input logic [7:0] yr);
        logic [1:0] yr_mod4;
        yr_mod4 = yr[1:0] + {yr[4], 1'b0};
        case (mon)
            8'h04, 8'h06, 8'h09, 8'h11: return 8'h30;
            8'h02:                      return (yr_mod4 == 2'd0) ? 8'h29 : 8'h28;
            default:                    return 8'h31;
        endcase
    endfunction

    assign evt  = ~nce2_q & nce1_q;
    assign tick = (presc_q == PW'(TICKDIV - 1));
    assign dmax = month_len(tm_q[55:48], tm_q[63:56]);

    always_comb begin
        tm_tick       = tm_q;
        tm_tick[7:0]  = bcd_inc(tm_q[7:0], 8'h00, 8'h99);
        if (tm_q[7:0] >= 8'h99) begin
            tm_tick[15:8] = bcd_inc(tm_q[15:8], 8'h00, 8'h59);
            if (tm_q[15:8] >= 8'h59) begin
                tm_tick[23:16] = bcd_inc(tm_q[23:16], 8'h00, 8'h59);
                if (tm_q[23:16] >= 8'h59) begin
                    tm_tick[31:24] = bcd_inc(tm_q[31:24], 8'h00, 8'h23);
                    if (tm_q[31:24] >= 8'h23) begin
                        tm_tick[39:32] = bcd_inc(tm_q[39:32], 8'h01, 8'h07);
                        tm_tick[47:40] = bcd_inc(tm_q[47:40], 8'h01, dmax);
                        if (tm_q[47:40] >= dmax) begin
                            tm_tick[55:48] = bcd_inc(tm_q[55:48], 8'h01, 8'h12);
                            if (tm_q[55:48] >= 8'h12)
                                tm_tick[63:56] = bcd_inc(tm_q[63:56], 8'h00, 8'h99);
                        end
                    end
                end
            end
        end
    end

    always_comb begin
        nce1_d  = nCE;
        nce2_d  = nce1_q;
        a0_d    = nce1_q ? a0_q : A0;
        a2_d    = nce1_q ? a2_q : A2;
        state_d = state_q;
        idx_d   = idx_q;
        dirty_d = dirty_q;
        sh_d    = sh_q;
        sh_w    = sh_q;
        dirty_w = dirty_q;
        presc_d = tick ? '0 : presc_q + PW'(1);
        tm_d    = tick ? tm_tick : tm_q;

        case (state_q)
            MATCH: begin
                if (evt) begin
                    if (!a0_q && (a2_q == KEY[idx_q])) begin
                        if (idx_q == 6'd63) begin
                            state_d = XFER;
                            idx_d   = '0;
                            sh_d    = tm_q;
                            dirty_d = 1'b0;
                        end else begin
                            idx_d = idx_q + 6'd1;
                        end
                    end else begin
                        idx_d = '0;
                    end
                end
            end
            XFER: begin
                if (evt) begin
                    if (!a0_q) begin
                        sh_w[idx_q] = a2_q;
                        dirty_w     = 1'b1;
                    end
                    sh_d    = sh_w;
                    dirty_d = dirty_w;
                    idx_d   = idx_q + 6'd1;
                    // Load beats a coincident tick; the prescaler restarts from the new time.
                    if (idx_q == 6'd63) begin
                        state_d = MATCH;
                        idx_d   = '0;
                        if (dirty_w) begin
                            tm_d    = sh_w & 64'hFFFF_FF07_7FFF_FFFF;
                            presc_d = '0;
                        end
                    end
                end
            end
            default: state_d = MATCH;
        endcase
    end

    assign RAMROMCSgb = (state_q == MATCH) ? ~nCE : 1'b0;
    assign DQ         = (state_q == XFER) ? sh_q[idx_q] : 1'b0;
    assign DQOE       = (state_q == XFER) & ~nCE & A0;

    always_ff @(posedge C7M) begin
        if (RES) begin
            nce1_q  <= 1'b1;
            nce2_q  <= 1'b1;
            a0_q    <= 1'b0;
            a2_q    <= 1'b0;
            state_q <= MATCH;
            idx_q   <= '0;
            dirty_q <= 1'b0;
            sh_q    <= '0;
            presc_q <= '0;
            tm_q    <= TIME_RESET;
        end else begin
            nce1_q  <= nce1_d;
            nce2_q  <= nce2_d;
            a0_q    <= a0_d;
            a2_q    <= a2_d;
            state_q <= state_d;
            idx_q   <= idx_d;
            dirty_q <= dirty_d;
            sh_q    <= sh_d;
            presc_q <= presc_d;
            tm_q    <= tm_d;
        end
    end

endmodule

// File: tb/tb_phantom_clock.sv
// Randomised bench for phantom_clock: drives memory accesses and compares against a
// decimal-arithmetic calendar/protocol model that runs alongside the DUT.
module tb_phantom_clock;

    localparam int TICKDIV_TB = 4;

    logic clk = 1'b0;
    logic RES, nCE, A0, A2;
    logic RAMROMCSgb, DQ, DQOE;

    logic [63:0] key_bits = 64'h5CA33AC55CA33AC5;
    int n_checks = 0;
    int n_fail   = 0;

    phantom_clock #(.TICKDIV(TICKDIV_TB)) dut (
        .C7M(clk), .RES(RES), .nCE(nCE), .A0(A0), .A2(A2),
        .RAMROMCSgb(RAMROMCSgb), .DQ(DQ), .DQOE(DQOE)
    );

    always #5 clk = ~clk;

    // Reference model state: time kept as plain decimal integers.
    bit          m_p1, m_p2, m_a0, m_a2, m_xfer, m_dirty;
    int          m_idx, m_presc;
    logic [63:0] m_sh;
    int          t_hs, t_s, t_mi, t_h, t_dw, t_dt, t_mo, t_y;
    logic [63:0] rd_word;

    function automatic logic [7:0] bcd(input int v);
        logic [7:0] r;
        r[7:4] = 4'(v / 10);
        r[3:0] = 4'(v % 10);
        return r;
    endfunction

    function automatic int dec(input logic [7:0] b);
        return int'(b[7:4]) * 10 + int'(b[3:0]);
    endfunction

    function automatic logic [63:0] mk_time(input int hs, s, mi, h, dw, dt, mo, y);
        return {bcd(y), bcd(mo), bcd(dt), bcd(dw), bcd(h), bcd(mi), bcd(s), bcd(hs)};
    endfunction

    function automatic int days_in(input int mo, input int y);
        if (mo == 2) return (y % 4 == 0) ? 29 : 28;
        if (mo == 4 || mo == 6 || mo == 9 || mo == 11) return 30;
        return 31;
    endfunction

    function void advance_time();
        if (t_hs < 99) begin t_hs++; return; end
        t_hs = 0;
        if (t_s < 59) begin t_s++; return; end
        t_s = 0;
        if (t_mi < 59) begin t_mi++; return; end
        t_mi = 0;
        if (t_h < 23) begin t_h++; return; end
        t_h  = 0;
        t_dw = (t_dw >= 7) ? 1 : t_dw + 1;
        if (t_dt < days_in(t_mo, t_y)) begin t_dt++; return; end
        t_dt = 1;
        if (t_mo < 12) begin t_mo++; return; end
        t_mo = 1;
        t_y  = (t_y >= 99) ? 0 : t_y + 1;
    endfunction

    always @(posedge clk) begin : ref_model
        bit evt, tick, load;
        if (RES) begin
            m_p1 = 1; m_p2 = 1; m_a0 = 0; m_a2 = 0;
            m_xfer = 0; m_idx = 0; m_dirty = 0; m_sh = '0; m_presc = 0;
            t_hs = 0; t_s = 0; t_mi = 0; t_h = 0; t_dw = 1; t_dt = 1; t_mo = 1; t_y = 0;
        end else begin
            evt  = !m_p2 && m_p1;
            tick = (m_presc == TICKDIV_TB - 1);
            load = 0;
            if (evt && !m_xfer) begin
                if (!m_a0 && m_a2 == key_bits[m_idx]) begin
                    if (m_idx == 63) begin
                        m_xfer = 1; m_idx = 0; m_dirty = 0;
                        m_sh = mk_time(t_hs, t_s, t_mi, t_h, t_dw, t_dt, t_mo, t_y);
                    end else m_idx++;
                end else m_idx = 0;
            end else if (evt) begin
                if (!m_a0) begin m_sh[m_idx] = m_a2; m_dirty = 1; end
                if (m_idx == 63) begin m_xfer = 0; m_idx = 0; load = m_dirty; end
                else m_idx++;
            end
            if (load) begin
                t_hs = dec(m_sh[7:0]);   t_s  = dec(m_sh[15:8]);
                t_mi = dec(m_sh[23:16]); t_h  = dec(m_sh[31:24] & 8'h7F);
                t_dw = int'(m_sh[34:32]); t_dt = dec(m_sh[47:40]);
                t_mo = dec(m_sh[55:48]); t_y  = dec(m_sh[63:56]);
                m_presc = 0;
            end else if (tick) begin
                m_presc = 0;
                advance_time();
            end else m_presc++;
            if (!m_p1) begin m_a0 = A0; m_a2 = A2; end
            m_p2 = m_p1;
            m_p1 = nCE;
        end
    end

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // One memory access; align stretches the access so its end lands on a prescaler wrap.
    task automatic applyStimulus(input bit a0, input bit a2, input bit align, output bit gate);
        int lo;
        @(negedge clk);
        A0 = a0; A2 = a2; nCE = 1'b0;
        lo = $urandom_range(1, 3);
        repeat (lo) @(negedge clk);
        if (align)
            for (int t = 0; t < 8 && m_presc != TICKDIV_TB - 2; t++) @(negedge clk);
        gate = RAMROMCSgb;
        if (m_xfer) begin
            checkOutput("gate_xfer", RAMROMCSgb, 0);
            checkOutput("dqoe_xfer", DQOE, a0);
            checkOutput("dq_bit", DQ, m_sh[m_idx]);
            rd_word[m_idx] = DQ;
        end else begin
            checkOutput("gate_match", RAMROMCSgb, 1);
            checkOutput("dqoe_match", DQOE, 0);
        end
        nCE = 1'b1;
        #1;
        checkOutput("dqoe_idle", DQOE, 0);
        checkOutput("gate_idle", RAMROMCSgb, 0);
        repeat (3) @(negedge clk);
    endtask

    task automatic send_key(input logic [63:0] k);
        bit g;
        applyStimulus(1'b1, 1'b0, 1'b0, g);
        for (int i = 0; i < 64; i++) applyStimulus(1'b0, k[i], 1'b0, g);
    endtask

    task automatic write_word(input logic [63:0] w, input bit align);
        bit g;
        send_key(key_bits);
        for (int i = 0; i < 64; i++) applyStimulus(1'b0, w[i], align && (i == 63), g);
    endtask

    task automatic read_word(output logic [63:0] w, output logic [63:0] exp, output bit g0);
        bit g;
        send_key(key_bits);
        exp = m_sh;
        for (int i = 0; i < 64; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, g);
            if (i == 0) g0 = g;
        end
        w = rd_word;
    endtask

    task automatic pulse_reset();
        @(negedge clk); RES = 1'b1;
        @(negedge clk); RES = 1'b0;
    endtask

    initial begin
        logic [63:0] w, exp, k;
        bit g, g0, g_or;
        RES = 1'b1; nCE = 1'b1; A0 = 1'b0; A2 = 1'b0; rd_word = '0;
        repeat (3) @(negedge clk);
        checkOutput("rst_gate_idle", RAMROMCSgb, 0);
        nCE = 1'b0; A0 = 1'b1; #1;
        checkOutput("rst_gate_sel", RAMROMCSgb, 1);
        checkOutput("rst_dqoe", DQOE, 0);
        checkOutput("rst_dq", DQ, 0);
        nCE = 1'b1; A0 = 1'b0;
        @(negedge clk); RES = 1'b0;

        // Key then 64 mixed accesses, all with memory suppressed.
        send_key(key_bits);
        g_or = 1'b0;
        for (int i = 0; i < 64; i++) begin
            applyStimulus(1'(($urandom_range(0, 1))), m_sh[m_idx], 1'b0, g);
            g_or |= g;
        end
        checkOutput("xfer_suppressed", g_or, 0);
        applyStimulus(1'b1, 1'b0, 1'b0, g);
        checkOutput("back_to_match", g, 1);

        pulse_reset();
        read_word(w, exp, g0);
        checkOutput("key_enter", g0, 0);
        checkOutput("reset_snap", w, exp);
        checkOutput("reset_snap_fields", w[63:24], 40'h00_01_01_01_00);

        // Corrupted key is rejected; a read event in the middle of the key restarts it.
        k = key_bits; k[40] = ~k[40];
        send_key(k);
        applyStimulus(1'b1, 1'b0, 1'b0, g);
        checkOutput("corrupt_rejected", g, 1);
        read_word(w, exp, g0);
        checkOutput("key_after_corrupt", g0, 0);
        checkOutput("snap_after_corrupt", w, exp);
        applyStimulus(1'b1, 1'b0, 1'b0, g);
        for (int i = 0; i < 20; i++) applyStimulus(1'b0, key_bits[i], 1'b0, g);
        applyStimulus(1'b1, 1'b0, 1'b0, g);
        for (int i = 20; i < 64; i++) applyStimulus(1'b0, key_bits[i], 1'b0, g);
        applyStimulus(1'b1, 1'b0, 1'b0, g);
        checkOutput("midkey_reset", g, 1);

        write_word(mk_time(99, 59, 59, 23, 3, 28, 2, 0), 1'b0);
        read_word(w, exp, g0);
        checkOutput("leap_snap", w, exp);
        checkOutput("leap_feb29", w[63:16], 48'h00_02_29_04_00_00);

        write_word(mk_time(99, 59, 59, 23, 3, 28, 2, 1), 1'b0);
        read_word(w, exp, g0);
        checkOutput("nonleap_snap", w, exp);
        checkOutput("nonleap_mar01", w[63:16], 48'h01_03_01_04_00_00);

        write_word(mk_time(99, 59, 59, 23, 7, 31, 12, 99), 1'b0);
        read_word(w, exp, g0);
        checkOutput("yearwrap_snap", w, exp);
        checkOutput("yearwrap_jan01", w[63:16], 48'h00_01_01_01_00_00);

        write_word(mk_time(50, 30, 10, 12, 5, 15, 6, 42), 1'b1);
        read_word(w, exp, g0);
        checkOutput("collision_snap", w, exp);

        // Reset in the middle of a write transfer must discard it.
        write_word(mk_time(0, 0, 30, 10, 2, 10, 5, 20), 1'b0);
        send_key(key_bits);
        for (int i = 0; i < 30; i++) applyStimulus(1'b0, 1'(($urandom_range(0, 1))), 1'b0, g);
        pulse_reset();
        applyStimulus(1'b1, 1'b0, 1'b0, g);
        checkOutput("reset_abort", g, 1);
        read_word(w, exp, g0);
        checkOutput("abort_snap", w, exp);
        checkOutput("abort_fields", w[63:16], 48'h00_01_01_01_00_00);

        for (int r = 0; r < 4; r++) begin
            int mo;
            mo = $urandom_range(1, 12);
            write_word(mk_time($urandom_range(90, 99), $urandom_range(55, 59),
                               $urandom_range(55, 59), $urandom_range(20, 23),
                               $urandom_range(1, 7), $urandom_range(26, days_in(mo, 0)),
                               mo, $urandom_range(0, 99)), 1'(($urandom_range(0, 1))));
            repeat ($urandom_range(0, 5))
                applyStimulus(1'(($urandom_range(0, 1))), 1'(($urandom_range(0, 1))), 1'b0, g);
            read_word(w, exp, g0);
            checkOutput("rand_snap", w, exp);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_fail);
        $finish;
    end

endmodule
